// File: rtl/j1_io_responder_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : j1_io_responder_if                                            |
// | Purpose  : J1 core IO bus plus TX byte stream, bundled for the responder |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface j1_io_responder_if #(
  parameter int WIDTH = 16
);
  logic [15:0]      memory_address;
  logic             io_write_enable;
  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] io_data_in;
  logic [7:0]       leds;
  logic             tx_valid;
  logic [7:0]       tx_data;
  logic             tx_ready;

  // Core plus downstream serializer side
  modport master (
    output memory_address, io_write_enable, data_out, tx_ready,
    input  io_data_in, leds, tx_valid, tx_data
  );

  // Responder side
  modport slave (
    input  memory_address, io_write_enable, data_out, tx_ready,
    output io_data_in, leds, tx_valid, tx_data
  );
endinterface
`default_nettype wire

// File: rtl/j1_io_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : j1_io_responder                                               |
// | Purpose  : Memory-mapped IO block for the J1 core: LED register, TX byte  |
// |            FIFO with sticky overflow status, optional tick counter.      |
// |            Define J1_IO_TICK_EN to build the tick counter at 0x3000.     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module j1_io_responder #(
  parameter int WIDTH      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input logic              clock,
  input logic              active_low_reset,
  j1_io_responder_if.slave bus
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  localparam logic [15:0] ADDR_LED    = 16'h1000;
  localparam logic [15:0] ADDR_TXDATA = 16'h2000;
  localparam logic [15:0] ADDR_TXSTAT = 16'h2001;
  localparam logic [15:0] ADDR_TICK   = 16'h3000;

  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic [7:0]       leds_q;
  logic [WIDTH-1:0] rd_data_q;

  logic             fifo_empty;
  logic             fifo_full;
  logic             do_pop;
  logic             push_req;
  logic             push_accept;
  logic             ovf_set;
  logic             ovf_clr;
  logic             led_we;
  logic [WIDTH-1:0] status_word;
  logic [WIDTH-1:0] tick_value;
  logic [WIDTH-1:0] rd_mux;

  assign fifo_empty  = (count == '0);
  assign fifo_full   = (count == CNT_W'(FIFO_DEPTH));
  assign do_pop      = !fifo_empty && bus.tx_ready;
  assign push_req    = bus.io_write_enable && (bus.memory_address == ADDR_TXDATA);
  // A full FIFO still takes a push when the head leaves at the same edge
  assign push_accept = push_req && (!fifo_full || do_pop);
  assign ovf_set     = push_req && !push_accept;
  assign ovf_clr     = bus.io_write_enable && (bus.memory_address == ADDR_TXSTAT);
  assign led_we      = bus.io_write_enable && (bus.memory_address == ADDR_LED);

`ifdef J1_IO_TICK_EN
  logic             tick_we;
  logic [WIDTH-1:0] tick_count;
  assign tick_we = bus.io_write_enable && (bus.memory_address == ADDR_TICK);

  // Free-running tick counter; a write loads it and counting resumes from there
  always_ff @(posedge clock or negedge active_low_reset) begin
    if (!active_low_reset) begin
      tick_count <= '0;
    end else if (tick_we) begin
      tick_count <= bus.data_out;
    end else begin
      tick_count <= tick_count + WIDTH'(1);
    end
  end
  assign tick_value = tick_count;
`else
  assign tick_value = '0;
`endif

  // Status word: not-full, empty, sticky overflow, occupancy in bits 7:3
  always_comb begin
    status_word      = '0;
    status_word[0]   = !fifo_full;
    status_word[1]   = fifo_empty;
    status_word[2]   = overflow;
    status_word[7:3] = 5'(count);
  end

  // Read select from pre-edge state; TX data reads back as zero
  always_comb begin
    rd_mux = '0;
    case (bus.memory_address)
      ADDR_LED:    rd_mux = WIDTH'(leds_q);
      ADDR_TXSTAT: rd_mux = status_word;
      ADDR_TICK:   rd_mux = tick_value;
      default:     rd_mux = '0;
    endcase
  end

  // FIFO storage needs no reset: the head is masked while empty
  always_ff @(posedge clock) begin
    if (push_accept) begin
      fifo_mem[wr_ptr] <= bus.data_out[7:0];
    end
  end

  // FIFO pointers, occupancy and sticky overflow (set beats clear)
  always_ff @(posedge clock or negedge active_low_reset) begin
    if (!active_low_reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_accept) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)      rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_accept, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (ovf_set) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

  // LED register and registered read data
  always_ff @(posedge clock or negedge active_low_reset) begin
    if (!active_low_reset) begin
      leds_q    <= 8'h00;
      rd_data_q <= '0;
    end else begin
      if (led_we) leds_q <= bus.data_out[7:0];
      rd_data_q <= rd_mux;
    end
  end

  assign bus.io_data_in = rd_data_q;
  assign bus.leds       = leds_q;
  assign bus.tx_valid   = !fifo_empty;
  assign bus.tx_data    = fifo_empty ? 8'h00 : fifo_mem[rd_ptr];

endmodule
`default_nettype wire

// File: doc/j1_io_responder.md
J1_IO_RESPONDER -- requirements
Module: j1_io_responder

Interface
REQ-001 Parameter WIDTH, default 16: core data width; matches the core's `WIDTH.
REQ-002 Parameter FIFO_DEPTH, default 4: TX FIFO entries; SHALL be a power of two, minimum 2.
REQ-003 clock  input  1  single clock for all state.
REQ-004 active_low_reset  input  1  asynchronous, active-low reset.
REQ-005 memory_address  input  16  core address bus, decoded for IO.
REQ-006 io_write_enable  input  1  core IO write strobe.
REQ-007 data_out  input  WIDTH  core write data.
REQ-008 io_data_in  output  WIDTH  registered IO read data returned to the core.
REQ-009 leds  output  8  LED register contents.
REQ-010 tx_valid  output  1  TX FIFO head valid (FIFO not empty).
REQ-011 tx_data  output  8  TX FIFO head byte.
REQ-012 tx_ready  input  1  downstream serializer accepts head when high with tx_valid.

Function
REQ-013 Address map: 0x1000 LED (R/W); 0x2000 TX data (W push, R 0); 0x2001 TX status (R; W clears overflow); 0x3000 tick counter (R/W); any other address SHALL read 0 and ignore writes.
REQ-014 A write SHALL occur at a rising edge only when io_write_enable=1; address and data are sampled at that edge.
REQ-015 LED write: leds <= data_out[7:0]; LED read returns {zeros, leds}.
REQ-016 Read latency one cycle: io_data_in after edge N SHALL reflect the register selected by memory_address at edge N, using state before any write at edge N.
REQ-017 TX push: write to 0x2000 enqueues data_out[7:0] at the tail.
REQ-018 TX pop: when tx_valid=1 and tx_ready=1 at an edge, the head is removed; tx_data SHALL show the next entry in the following cycle.
REQ-019 tx_valid = (count != 0); tx_data SHALL be the head entry, 0 when empty.
REQ-020 Push while full with no pop the same edge: byte dropped, count unchanged, sticky overflow set.
REQ-021 Push and pop at the same edge while full: both accepted, count unchanged, overflow not set.
REQ-022 Push and pop at the same edge while not empty and not full: count unchanged, FIFO order preserved.
REQ-023 Push while empty: tx_valid=1 in the following cycle; no same-cycle bypass.
REQ-024 Pointers wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH inclusive.
REQ-025 Status read: bit0 = not full, bit1 = empty, bit2 = overflow, bits[7:3] = count, remaining bits 0.
REQ-026 Overflow clear (write to 0x2001) at the same edge as an overflowing push: set wins.
REQ-027 Tick counter: WIDTH bits, +1 every cycle, wraps from all-ones to 0.
REQ-028 Tick write loads data_out; the counter then increments from that value on the next edge.

Reset
REQ-029 While active_low_reset=0, asynchronously: io_data_in=0, leds=0, FIFO empty (tx_valid=0, tx_data=0), overflow=0, tick counter=0.
REQ-030 Reset asserted mid-traffic SHALL discard all FIFO contents; no pop is reported after reset.
REQ-031 After deassertion, the first edge performs normal operation.

Configuration
REQ-032 Macro J1_IO_TICK_EN defined: the tick counter is implemented per REQ-027/028.
REQ-033 Macro J1_IO_TICK_EN undefined: no counter logic; 0x3000 reads 0 and writes are ignored.

Verification
REQ-034 Reset, then write 0x1000 = 0x00A5 -> leds=0xA5; read 0x1000 -> io_data_in=0x00A5 one cycle later.
REQ-035 tx_ready=0; push 0x11,0x22,0x33,0x44 -> status=0x0020 (count 4, full, not empty); push 0x55 -> status=0x0024; release tx_ready -> tx_data 0x11,0x22,0x33,0x44 on consecutive cycles, then tx_valid=0.
REQ-036 FIFO full, tx_ready=1, push 0x66 at the same edge -> count stays 4, overflow=0, 0x66 drains last.
REQ-037 With J1_IO_TICK_EN: write 0x3000 = 0xFFFE -> reads show 0xFFFF, then 0x0000 (wrap); without the macro -> reads show 0.
REQ-038 Assert reset with 3 bytes queued and leds=0x5A -> tx_valid=0, leds=0, status read after release = 0x0003.
